// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: ALU operation codes, instruction opcodes,
// instruction field positions and the opcode-to-ALU-operation decode.
package custom_types;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_LT
  } alu_operation_t;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_LT,
    OP_NOP,
    OP_ILLEGAL
  } opcode_t;

  localparam int INSTR_W  = 12;
  localparam int OPC_MSB  = 11;
  localparam int OPC_LSB  = 9;
  localparam int IMM_BIT  = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 6;
  localparam int RS1_MSB  = 5;
  localparam int RS1_LSB  = 4;
  localparam int IMM4_MSB = 3;
  localparam int IMM4_LSB = 0;
  localparam int RS2_MSB  = 1;
  localparam int RS2_LSB  = 0;

  // NOP and illegal still drive a harmless ADD into the ALU.
  function automatic alu_operation_t decode_op(opcode_t op);
    alu_operation_t res;
    res = ALU_ADD;
    case (op)
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      OP_LT:   res = ALU_LT;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake plus the operand/result bus to the combinational ALU.
interface alu_issue_stage_if #(
  parameter int DATA_W = 4
);
  import custom_types::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_W-1:0]   instr;
  logic [DATA_W-1:0]    alu_op1;
  logic [DATA_W-1:0]    alu_op2;
  alu_operation_t       alu_operation;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_zero;

  modport master (
    output instr_valid, instr, alu_result, alu_zero,
    input  instr_ready, alu_op1, alu_op2, alu_operation
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero,
    output instr_ready, alu_op1, alu_op2, alu_operation
  );

endinterface

// File: rtl/alu_issue_stage_regfile.sv
// Register file: two operand read ports, one debug read port, one synchronous write port.
module alu_issue_stage_regfile #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = mem_q[raddr1_i];
  assign rdata2_o   = mem_q[raddr2_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/writeback pipeline (EX, WB) feeding an external combinational ALU,
// with single-level forwarding from WB into EX operand selection.
module alu_issue_stage
  import custom_types::*;
#(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  alu_issue_stage_if.slave  bus,
  output logic              wb_valid_o,
  output logic [AW-1:0]     wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              zero_flag_o,
  output logic              illegal_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic              ex_valid_q, ex_valid_d;
  opcode_t           ex_opc_q, ex_opc_d;
  logic              ex_imm_q, ex_imm_d;
  logic [AW-1:0]     ex_rd_q, ex_rd_d;
  logic [AW-1:0]     ex_rs1_q, ex_rs1_d;
  logic [AW-1:0]     ex_rs2_q, ex_rs2_d;
  logic [DATA_W-1:0] ex_imm4_q, ex_imm4_d;

  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_zero_q, wb_zero_d;

  logic              zero_flag_q, zero_flag_d;
  logic              illegal_q, illegal_d;

  logic [DATA_W-1:0] op1_hold_q, op2_hold_q;
  alu_operation_t    opn_hold_q;

  logic              advance, ex_writes, rf_we;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, fwd1, fwd2;

  alu_issue_stage_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .we_i       (rf_we),
    .waddr_i    (wb_rd_q),
    .wdata_i    (wb_data_q),
    .raddr1_i   (ex_rs1_q),
    .rdata1_o   (rf_rdata1),
    .raddr2_i   (ex_rs2_q),
    .rdata2_o   (rf_rdata2),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  assign advance   = !stall_i;
  assign ex_writes = ex_valid_q && (ex_opc_q != OP_NOP) && (ex_opc_q != OP_ILLEGAL);
  assign rf_we     = wb_valid_q && advance;

  // The regfile is written at the close of WB, so WB is the only stage to forward from.
  assign fwd1 = (wb_valid_q && (wb_rd_q == ex_rs1_q)) ? wb_data_q : rf_rdata1;
  assign fwd2 = (wb_valid_q && (wb_rd_q == ex_rs2_q)) ? wb_data_q : rf_rdata2;

  assign bus.instr_ready   = advance;
  assign bus.alu_op1       = ex_valid_q ? fwd1 : op1_hold_q;
  assign bus.alu_op2       = ex_valid_q ? (ex_imm_q ? ex_imm4_q : fwd2) : op2_hold_q;
  assign bus.alu_operation = ex_valid_q ? decode_op(ex_opc_q) : opn_hold_q;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_opc_d    = ex_opc_q;
    ex_imm_d    = ex_imm_q;
    ex_rd_d     = ex_rd_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_imm4_d   = ex_imm4_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_zero_d   = wb_zero_q;
    zero_flag_d = zero_flag_q;
    illegal_d   = illegal_q;

    if (advance) begin
      ex_valid_d = bus.instr_valid;
      if (bus.instr_valid) begin
        ex_opc_d  = opcode_t'(bus.instr[OPC_MSB:OPC_LSB]);
        ex_imm_d  = bus.instr[IMM_BIT];
        ex_rd_d   = bus.instr[RD_MSB:RD_LSB];
        ex_rs1_d  = bus.instr[RS1_MSB:RS1_LSB];
        ex_rs2_d  = bus.instr[RS2_MSB:RS2_LSB];
        ex_imm4_d = DATA_W'(bus.instr[IMM4_MSB:IMM4_LSB]);
      end

      wb_valid_d = ex_writes;
      if (ex_writes) begin
        wb_rd_d   = ex_rd_q;
        wb_data_d = bus.alu_result;
        wb_zero_d = bus.alu_zero;
      end

      if (ex_valid_q && (ex_opc_q == OP_ILLEGAL)) illegal_d = 1'b1;
      if (wb_valid_q) zero_flag_d = wb_zero_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_valid_q  <= 1'b0;
      ex_opc_q    <= OP_NOP;
      ex_imm_q    <= 1'b0;
      ex_rd_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_imm4_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_zero_q   <= 1'b0;
      zero_flag_q <= 1'b0;
      illegal_q   <= 1'b0;
      op1_hold_q  <= '0;
      op2_hold_q  <= '0;
      opn_hold_q  <= ALU_ADD;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opc_q    <= ex_opc_d;
      ex_imm_q    <= ex_imm_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_imm4_q   <= ex_imm4_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_zero_q   <= wb_zero_d;
      zero_flag_q <= zero_flag_d;
      illegal_q   <= illegal_d;
      op1_hold_q  <= bus.alu_op1;
      op2_hold_q  <= bus.alu_op2;
      opn_hold_q  <= bus.alu_operation;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign zero_flag_o = zero_flag_q;
  assign illegal_o   = illegal_q;

endmodule
